// File: rtl/apb_mem_slave_v2_if.sv
// APB4 bus bundle for apb_mem_slave_v2: request signals from the master,
// completion/data/error back from the slave.
interface apb_mem_slave_v2_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_mem_slave_v2.sv
// APB4 word-addressed RAM slave with byte strobes, programmable wait states,
// base-address decode and PSLVERR for out-of-range or misaligned accesses.
module apb_mem_slave_v2 #(
    parameter int                 DATA_W      = 32,
    parameter int                 ADDR_W      = 32,
    parameter int                 DEPTH       = 256,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int                 WAIT_STATES = 0
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_mem_slave_v2_if.slave   apb
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
    localparam logic [3:0]        WAIT_INIT  = 4'(WAIT_STATES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               pready_q, pready_d;
    logic               pslverr_q, pslverr_d;
    logic [DATA_W-1:0]  prdata_q, prdata_d;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0]  off;
    logic [ADDR_W-1:0]  idxFull;
    logic [IDX_W-1:0]   memIdx;
    logic               addrErr;
    logic               start;
    logic               commit;
    logic               memWe;

    // BASE_ADDR is aligned to the window size, so offset alignment equals paddr alignment.
    assign off     = apb.paddr - BASE_ADDR;
    assign idxFull = off >> OFF_W;
    assign memIdx  = idxFull[IDX_W-1:0];
    assign addrErr = (apb.paddr < BASE_ADDR) || (idxFull >= DEPTH_A) ||
                     ((off & ALIGN_MASK) != '0);

    // The !pready term stops the still-asserted access phase re-triggering during RESP.
    assign start = apb.psel & apb.penable & ~pready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!apb.psel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Response registers are loaded only on the edge entering RESP; both strobes drop after it.
    always_comb begin
        pready_d  = commit;
        pslverr_d = commit & addrErr;
        prdata_d  = prdata_q;
        if (commit) begin
            prdata_d = (!apb.pwrite && !addrErr) ? mem[memIdx] : '0;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // RAM has no reset; gating with presetn drops a write that coincides with reset.
    assign memWe = commit & apb.pwrite & ~addrErr & presetn;

    always_ff @(posedge pclk) begin
        if (memWe) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (apb.pstrb[k]) begin
                    mem[memIdx][k*8 +: 8] <= apb.pwdata[k*8 +: 8];
                end
            end
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;

endmodule
